// File: rtl/pipeline_control_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states and the
// per-latch enable/flush control pair.
package pipeline_control_pkg;

  typedef enum logic [1:0] {
    PC_RUN,
    PC_DWAIT,
    PC_DRAIN,
    PC_HALTED
  } pctl_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_HOLD  = '{en: 1'b0, flush: 1'b0};
  localparam pipe_ctl_t CTL_ADV   = '{en: 1'b1, flush: 1'b0};
  localparam pipe_ctl_t CTL_FLUSH = '{en: 1'b0, flush: 1'b1};

  // A flush always wins over an enable on the same latch.
  function automatic logic ctl_en(input pipe_ctl_t c);
    return c.en & ~c.flush;
  endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// Handshake bundle between the pipeline sequencer and its environment:
// hazard/memory status in, latch strobes, halt and perf counters out.
interface pipeline_control_if #(parameter int CNT_W = 32);

  logic             ihit;
  logic             dhit;
  logic             mem_ren;
  logic             mem_wen;
  logic             hz_stall;
  logic             br_taken;
  logic             mem_halt;

  logic             pc_en;
  logic             fd_en;
  logic             fd_flush;
  logic             dx_en;
  logic             dx_flush;
  logic             xm_en;
  logic             xm_flush;
  logic             mw_en;
  logic             mw_flush;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport pc (
    input  ihit, dhit, mem_ren, mem_wen, hz_stall, br_taken, mem_halt,
    output pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_en, xm_flush,
           mw_en, mw_flush, halt, stall_cnt, flush_cnt
  );

  modport tb (
    output ihit, dhit, mem_ren, mem_wen, hz_stall, br_taken, mem_halt,
    input  pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_en, xm_flush,
           mw_en, mw_flush, halt, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_control_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones
// instead of wrapping.
module pipeline_control_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = {W{1'b1}};
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// Central stall/flush sequencer for the 5-stage pipeline: arbitrates memory
// waits, halt drain, redirects, hazard bubbles and fetch misses into strobes.
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  pipeline_control_if.pc bus
);

  pctl_state_t state;
  pctl_state_t next_state;
  pipe_ctl_t   fd_ctl;
  pipe_ctl_t   dx_ctl;
  pipe_ctl_t   xm_ctl;
  pipe_ctl_t   mw_ctl;
  logic        pc_load;
  logic        br_accept;
  logic        dreq;
  logic        freeze;
  logic        halt_q;
  logic        stall_inc;
  logic        flush_inc;

  assign dreq = bus.mem_ren | bus.mem_wen;

  // In DWAIT the access is already outstanding, so only dhit matters.
  assign freeze = (state == PC_RUN) ? (dreq & ~bus.dhit) : ~bus.dhit;

  always_comb begin
    pc_load    = 1'b0;
    br_accept  = 1'b0;
    fd_ctl     = CTL_HOLD;
    dx_ctl     = CTL_HOLD;
    xm_ctl     = CTL_HOLD;
    mw_ctl     = CTL_HOLD;
    next_state = state;
    if (rst) begin
      fd_ctl     = CTL_FLUSH;
      dx_ctl     = CTL_FLUSH;
      xm_ctl     = CTL_FLUSH;
      mw_ctl     = CTL_FLUSH;
      next_state = PC_RUN;
    end else begin
      case (state)
        PC_RUN, PC_DWAIT: begin
          if (freeze) begin
            next_state = PC_DWAIT;
          end else if (bus.mem_halt) begin
            fd_ctl     = CTL_FLUSH;
            dx_ctl     = CTL_FLUSH;
            xm_ctl     = CTL_ADV;
            mw_ctl     = CTL_ADV;
            next_state = PC_DRAIN;
          end else if (bus.br_taken) begin
            // Redirect discards wrong-path work regardless of hazard or fetch state.
            pc_load    = 1'b1;
            br_accept  = 1'b1;
            fd_ctl     = CTL_FLUSH;
            dx_ctl     = CTL_FLUSH;
            xm_ctl     = CTL_ADV;
            mw_ctl     = CTL_ADV;
            next_state = PC_RUN;
          end else if (bus.hz_stall) begin
            dx_ctl     = CTL_FLUSH;
            xm_ctl     = CTL_ADV;
            mw_ctl     = CTL_ADV;
            next_state = PC_RUN;
          end else if (!bus.ihit) begin
            fd_ctl     = CTL_FLUSH;
            dx_ctl     = CTL_ADV;
            xm_ctl     = CTL_ADV;
            mw_ctl     = CTL_ADV;
            next_state = PC_RUN;
          end else begin
            pc_load    = 1'b1;
            fd_ctl     = CTL_ADV;
            dx_ctl     = CTL_ADV;
            xm_ctl     = CTL_ADV;
            mw_ctl     = CTL_ADV;
            next_state = PC_RUN;
          end
        end
        PC_DRAIN: begin
          mw_ctl     = CTL_ADV;
          next_state = PC_HALTED;
        end
        default: begin
          next_state = PC_HALTED;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= PC_RUN;
      halt_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == PC_DRAIN) begin
        halt_q <= 1'b1;
      end
    end
  end

  assign stall_inc = ~rst & ((state == PC_RUN) | (state == PC_DWAIT)) & ~pc_load;
  assign flush_inc = ~rst & br_accept;

  pipeline_control_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_inc),
    .count (bus.stall_cnt)
  );

  pipeline_control_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (flush_inc),
    .count (bus.flush_cnt)
  );

  assign bus.pc_en    = pc_load;
  assign bus.fd_en    = ctl_en(fd_ctl);
  assign bus.fd_flush = fd_ctl.flush;
  assign bus.dx_en    = ctl_en(dx_ctl);
  assign bus.dx_flush = dx_ctl.flush;
  assign bus.xm_en    = ctl_en(xm_ctl);
  assign bus.xm_flush = xm_ctl.flush;
  assign bus.mw_en    = ctl_en(mw_ctl);
  assign bus.mw_flush = mw_ctl.flush;
  assign bus.halt     = halt_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed scoreboard bench for pipeline_control: expected strobes are queued
// when each step is driven and popped for comparison mid-cycle.
module tb_pipeline_control;

  localparam int CNT_W = 4;

  // Strobe vector order: {pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_en, xm_flush, mw_en, mw_flush}
  localparam logic [8:0] S_ALL_EN = 9'b1_10_10_10_10;
  localparam logic [8:0] S_FREEZE = 9'b0_00_00_00_00;
  localparam logic [8:0] S_RESET  = 9'b0_01_01_01_01;
  localparam logic [8:0] S_HZ     = 9'b0_00_01_10_10;
  localparam logic [8:0] S_BR     = 9'b1_01_01_10_10;
  localparam logic [8:0] S_HALT   = 9'b0_01_01_10_10;
  localparam logic [8:0] S_IMISS  = 9'b0_01_10_10_10;
  localparam logic [8:0] S_DRAIN  = 9'b0_00_00_00_10;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  logic [9:0] exp_q[$];
  string      tag_q[$];

  pipeline_control_if #(.CNT_W(CNT_W)) bus ();

  pipeline_control #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput();
    logic [9:0] expv;
    logic [9:0] obs;
    string      tag;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    expv = exp_q.pop_front();
    tag  = tag_q.pop_front();
    obs  = {bus.pc_en, bus.fd_en, bus.fd_flush, bus.dx_en, bus.dx_flush,
            bus.xm_en, bus.xm_flush, bus.mw_en, bus.mw_flush, bus.halt};
    compared++;
    assert (obs[9:1] === expv[9:1]) else begin
      mismatched++;
      $error("[TB] FAIL %s_strobes observed=%b expected=%b", tag, obs[9:1], expv[9:1]);
    end
    compared++;
    assert (obs[0] === expv[0]) else begin
      mismatched++;
      $error("[TB] FAIL %s_halt observed=%b expected=%b", tag, obs[0], expv[0]);
    end
  endtask

  task automatic checkCount(input string tag, input logic [CNT_W-1:0] observed,
                            input logic [CNT_W-1:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, queues the expectation, checks at the falling edge.
  task automatic applyStimulus(input string tag, input logic r, input logic ihit,
                               input logic dhit, input logic ren, input logic hz,
                               input logic br, input logic mhalt,
                               input logic [8:0] exp_strobes, input logic exp_halt);
    rst          = r;
    bus.ihit     = ihit;
    bus.dhit     = dhit;
    bus.mem_ren  = ren;
    bus.mem_wen  = 1'b0;
    bus.hz_stall = hz;
    bus.br_taken = br;
    bus.mem_halt = mhalt;
    exp_q.push_back({exp_strobes, exp_halt});
    tag_q.push_back(tag);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst          = 1'b1;
    bus.ihit     = 1'b1;
    bus.dhit     = 1'b0;
    bus.mem_ren  = 1'b0;
    bus.mem_wen  = 1'b0;
    bus.hz_stall = 1'b0;
    bus.br_taken = 1'b0;
    bus.mem_halt = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset");
    applyStimulus("reset", 1, 1, 0, 0, 0, 0, 0, S_RESET, 0);
    checkCount("reset_stall_cnt", bus.stall_cnt, 0);
    checkCount("reset_flush_cnt", bus.flush_cnt, 0);
    applyStimulus("run_idle", 0, 1, 0, 0, 0, 0, 0, S_ALL_EN, 0);

    $display("[TB] data miss");
    applyStimulus("dmiss_1", 0, 1, 0, 1, 0, 0, 0, S_FREEZE, 0);
    applyStimulus("dmiss_2", 0, 1, 0, 1, 0, 0, 0, S_FREEZE, 0);
    applyStimulus("dmiss_3", 0, 1, 0, 1, 0, 0, 0, S_FREEZE, 0);
    applyStimulus("dmiss_hit", 0, 1, 1, 1, 0, 0, 0, S_ALL_EN, 0);
    checkCount("dmiss_stall_cnt", bus.stall_cnt, 3);

    $display("[TB] branch over hazard");
    applyStimulus("br_hz", 0, 1, 0, 0, 1, 1, 0, S_BR, 0);
    checkCount("br_flush_cnt", bus.flush_cnt, 1);
    checkCount("br_stall_cnt", bus.stall_cnt, 3);

    $display("[TB] hazard stall");
    applyStimulus("hz_1", 0, 1, 0, 0, 1, 0, 0, S_HZ, 0);
    applyStimulus("hz_2", 0, 1, 0, 0, 1, 0, 0, S_HZ, 0);
    checkCount("hz_stall_cnt", bus.stall_cnt, 5);

    $display("[TB] fetch miss");
    applyStimulus("imiss", 0, 0, 0, 0, 0, 0, 0, S_IMISS, 0);
    checkCount("imiss_stall_cnt", bus.stall_cnt, 6);

    $display("[TB] branch during data wait");
    applyStimulus("dw_br_1", 0, 1, 0, 1, 0, 1, 0, S_FREEZE, 0);
    applyStimulus("dw_br_2", 0, 1, 0, 1, 0, 1, 0, S_FREEZE, 0);
    checkCount("dw_br_flush_held", bus.flush_cnt, 1);
    applyStimulus("dw_br_hit", 0, 1, 1, 1, 0, 1, 0, S_BR, 0);
    checkCount("dw_br_flush_cnt", bus.flush_cnt, 2);
    checkCount("dw_br_stall_cnt", bus.stall_cnt, 8);

    $display("[TB] stall saturation");
    for (int i = 0; i < 10; i++) begin
      applyStimulus("sat_hz", 0, 1, 0, 0, 1, 0, 0, S_HZ, 0);
    end
    checkCount("sat_stall_cnt", bus.stall_cnt, 15);
    checkCount("sat_flush_cnt", bus.flush_cnt, 2);

    $display("[TB] reset during data wait");
    applyStimulus("dw_pre_rst", 0, 1, 0, 1, 0, 0, 0, S_FREEZE, 0);
    applyStimulus("dw_rst", 1, 1, 0, 1, 0, 0, 0, S_RESET, 0);
    checkCount("dw_rst_stall_cnt", bus.stall_cnt, 0);
    checkCount("dw_rst_flush_cnt", bus.flush_cnt, 0);
    applyStimulus("post_rst_run", 0, 1, 0, 0, 0, 0, 0, S_ALL_EN, 0);

    $display("[TB] halt drain");
    applyStimulus("halt_accept", 0, 1, 0, 0, 0, 0, 1, S_HALT, 0);
    applyStimulus("halt_drain", 0, 1, 0, 0, 0, 0, 0, S_DRAIN, 0);
    applyStimulus("halted_1", 0, 0, 0, 0, 0, 1, 0, S_FREEZE, 1);
    applyStimulus("halted_2", 0, 1, 1, 1, 1, 1, 1, S_FREEZE, 1);
    checkCount("halt_stall_cnt", bus.stall_cnt, 1);
    checkCount("halt_flush_cnt", bus.flush_cnt, 0);
    applyStimulus("halt_clr", 1, 1, 0, 0, 0, 0, 0, S_RESET, 1);
    applyStimulus("halt_cleared", 0, 1, 0, 0, 0, 0, 0, S_ALL_EN, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
